// File: rtl/exp_golomb_coder_k.sv
// exp_golomb_coder_k: k-th order Exp-Golomb serial coder, one code bit per beat, MSB first.
// Build option EXP_GOLOMB_SIGNED_MAP_EN: treat dt_i as signed and apply the se(v) mapping first.
module exp_golomb_coder_k #(
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 3,
    parameter int MAX_K      = 7
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  dft_tm_i,
    input  logic [DATA_WIDTH-1:0] dt_i,
    input  logic [K_WIDTH-1:0]    k_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  dt_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i
);
`ifdef EXP_GOLOMB_SIGNED_MAP_EN
    localparam int VW = DATA_WIDTH + 2;
`else
    localparam int VW = DATA_WIDTH + 1;
`endif
    localparam int PW = $clog2(VW);

    typedef enum logic [1:0] {IDLE, FIND, PREFIX, SUFFIX} state_t;

    state_t             r_state, w_next;
    logic [VW-1:0]      r_v;
    logic [K_WIDTH-1:0] r_kc;
    logic [PW-1:0]      r_cnt, r_ptr;
    logic               w_rstn;
    logic [K_WIDTH-1:0] w_kc;
    logic [VW-1:0]      w_x, w_v;
    logic [PW-1:0]      w_n, w_kcn;

    assign w_rstn = dft_tm_i | rstn_i;
    assign w_kc   = (k_i > K_WIDTH'(MAX_K)) ? K_WIDTH'(MAX_K) : k_i;
`ifdef EXP_GOLOMB_SIGNED_MAP_EN
    logic [VW-1:0] w_se;
    logic          w_pos;
    assign w_se  = {{2{dt_i[DATA_WIDTH-1]}}, dt_i};
    assign w_pos = !dt_i[DATA_WIDTH-1] && (dt_i != '0);
    assign w_x   = w_pos ? (w_se << 1) - VW'(1) : VW'(0) - (w_se << 1);
`else
    assign w_x   = VW'(dt_i);
`endif
    assign w_v   = w_x + (VW'(1) << w_kc);
    assign w_kcn = PW'(r_kc);

    // priority encoder: index of the most significant 1 in the registered v
    always_comb begin
        w_n = '0;
        for (int i = 0; i < VW; i++)
            if (r_v[i]) w_n = PW'(i);
    end

    // state register
    always_ff @(posedge clk_i or negedge w_rstn)
        if (!w_rstn) r_state <= IDLE;
        else         r_state <= w_next;

    // next-state and output decode, all outputs from registered state only
    always_comb begin
        w_next  = r_state;
        ready_o = w_rstn && (r_state == IDLE);
        valid_o = (r_state == PREFIX) || (r_state == SUFFIX);
        dt_o    = (r_state == SUFFIX) && r_v[r_ptr];
        last_o  = (r_state == SUFFIX) && (r_ptr == '0);
        case (r_state)
            IDLE:    if (valid_i) w_next = FIND;
            FIND:    w_next = (w_n > w_kcn) ? PREFIX : SUFFIX;
            PREFIX:  if (ready_i && r_cnt == PW'(1)) w_next = SUFFIX;
            SUFFIX:  if (ready_i && r_ptr == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // datapath: capture symbol, load counters in FIND, count down on accepted beats
    always_ff @(posedge clk_i or negedge w_rstn)
        if (!w_rstn) begin
            r_v   <= '0;
            r_kc  <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
        end else begin
            case (r_state)
                IDLE:    if (valid_i) begin
                             r_v  <= w_v;
                             r_kc <= w_kc;
                         end
                FIND:    begin
                             r_cnt <= w_n - w_kcn;
                             r_ptr <= w_n;
                         end
                PREFIX:  if (ready_i) r_cnt <= r_cnt - PW'(1);
                SUFFIX:  if (ready_i) r_ptr <= r_ptr - PW'(1);
                default: ;
            endcase
        end
endmodule
